// File: rtl/uart_rx_if.sv
// uart_rx_if: 8-bit valid/ready byte stream, same fields as the transmit-side
// StreamBus.
//   data  : byte being offered
//   valid : data holds an undelivered byte
//   ready : consumer takes data on an edge where valid && ready
// master = producer (the receiver), slave = consumer.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver with a registered valid/ready byte
// output. It never stalls the line: a byte that arrives while the output
// register is still occupied is dropped and flagged with overrun, and a low
// stop bit is flagged with frame_err.
//   clk       : system clock
//   rst       : asynchronous reset, active low
//   rx        : serial line, asynchronous, idle high
//   bus       : byte stream out (data/valid out, ready in)
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, good byte lost because output was full
module uart_rx #(
    parameter int F    = 50000000,
    parameter int BAUD = 115200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_rx_if.master       bus,
    output logic            frame_err,
    output logic            overrun
);
    localparam int DIV  = F / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    // Two-flop synchronizer; both flops reset to the idle-high line level
    // so reset release never looks like a start bit.
    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx};
    end

    assign rx_s = sync_q[1];

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    idx_q,   idx_d;
    logic [7:0]    sr_q,    sr_d;
    logic [7:0]    data_q,  data_d;
    logic          valid_q, valid_d;
    logic          ferr_q,  ferr_d;
    logic          ovr_q,   ovr_d;
    logic          deliver;
    logic          load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Line sampling. Start is checked at mid-bit, after which every sample
    // lands DIV cycles later, i.e. at the middle of each following bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Line went back high before mid-bit: glitch.
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    sr_d  = {rx_s, sr_q[7:1]};
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Back to IDLE at mid-stop: the remaining half bit
                        // is the margin that lets gapless frames through.
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                // Line held low past the stop bit; resync on the next high.
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register. A byte loads when the register is empty or is
    // being drained on this same edge; otherwise it is lost (overrun).
    always_comb begin
        load    = deliver && (!valid_q || bus.ready);
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = deliver && !load;
        if (valid_q && bus.ready) valid_d = 1'b0;
        if (load) begin
            data_d  = sr_q;
            valid_d = 1'b1;
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
